key_pulse_gen: RTL and testbench

- Front end for the plot-switching key processor: turns three raw, bouncing, asynchronous push-button levels into clean single-`sysclk`-cycle pulses `Bt_Next`, `Bt_Pre` and `Bt_Auto`.
- Each channel is synchronised, debounced and edge-detected.
- `Bt_Next` and `Bt_Pre` also get hold-to-repeat, so plots can be scrolled by holding a button.
- Outputs connect directly to the key processor's button inputs, which expect at most one pulse per intended press.

---
 rtl/key_pkg.sv | 21 ++
 rtl/key_debounce_chan.sv | 95 +++++++++
 rtl/key_pulse_gen.sv | 61 ++++++
 tb/tb_key_pulse_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and types for the button front end: key indices,
// default timing in sysclk cycles, and the repeat-phase encoding.
package key_pkg;

    localparam int NUM_KEYS = 3;
    localparam int KEY_NEXT = 0;
    localparam int KEY_PRE  = 1;
    localparam int KEY_AUTO = 2;

    // 10 ms debounce, 0.5 s first repeat, 0.2 s repeat period at 100 MHz
    localparam int DEF_DEB_CYCLES = 1000000;
    localparam int DEF_RPT_DELAY  = 50000000;
    localparam int DEF_RPT_PERIOD = 20000000;
    localparam int DEF_CNT_W      = 28;

    typedef enum logic {
        PH_DELAY  = 1'b0,
        PH_PERIOD = 1'b1
    } rpt_phase_e;

endpackage

// File: rtl/key_debounce_chan.sv
// One button channel: two-flop synchroniser, debounce counter, stable level,
// press detection and optional hold-to-repeat. o_pulse is combinational from flops.
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD,
    parameter bit RPT_EN     = 1'b1,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_stable,
    output logic o_pulse
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PERIOD - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_dc;
    logic [CNT_W-1:0] r_hc;
    rpt_phase_e       r_phase;
    rpt_phase_e       w_phase_nxt;

    logic w_differ;
    logic w_toggle;
    logic w_press;
    logic w_hc_hit;
    logic w_rpt;
    logic w_hc_clr;

    assign w_differ = r_s2 ^ r_stable;
    assign w_toggle = w_differ && (r_dc == DEB_LAST);
    assign w_press  = r_stable & ~r_stable_d;
    assign w_hc_hit = (r_phase == PH_DELAY) ? (r_hc == DLY_LAST) : (r_hc == PER_LAST);
    // A repeat is dropped on the very cycle the debounced level is about to fall.
    assign w_rpt    = RPT_EN && r_stable && !w_toggle && !w_press && w_hc_hit;
    assign w_hc_clr = !r_stable || w_toggle || w_press || w_rpt;

    assign o_stable = r_stable;
    assign o_pulse  = w_press | w_rpt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_dc       <= '0;
            r_hc       <= '0;
        end else begin
            r_s1       <= i_raw;
            r_s2       <= r_s1;
            r_stable_d <= r_stable;
            if (!w_differ) begin
                r_dc <= '0;
            end else if (w_toggle) begin
                r_dc     <= '0;
                r_stable <= ~r_stable;
            end else begin
                r_dc <= sat_inc(r_dc);
            end
            r_hc <= w_hc_clr ? '0 : sat_inc(r_hc);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= PH_DELAY;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        if (!r_stable || w_toggle || w_press) begin
            w_phase_nxt = PH_DELAY;
        end else if (w_rpt) begin
            w_phase_nxt = PH_PERIOD;
        end
    end

endmodule

// File: rtl/key_pulse_gen.sv
// Button front end: three debounced channels, Next/Pre collision suppression
// and registered single-cycle outputs for the key processor.
module key_pulse_gen
    import key_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD,
    parameter bit RPT_EN     = 1'b1,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                sysclk,
    input  logic                sysrst_n,
    input  logic [NUM_KEYS-1:0] Btn_Raw,
    output logic                Bt_Next,
    output logic                Bt_Pre,
    output logic                Bt_Auto,
    output logic [NUM_KEYS-1:0] Btn_Stable
);

    logic [NUM_KEYS-1:0] w_pulse;
    logic [NUM_KEYS-1:0] w_stable;
    logic                r_next;
    logic                r_pre;
    logic                r_auto;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        key_debounce_chan #(
            .DEB_CYCLES (DEB_CYCLES),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD),
            .RPT_EN     ((g == KEY_AUTO) ? 1'b0 : RPT_EN),
            .CNT_W      (CNT_W)
        ) u_chan (
            .i_clk    (sysclk),
            .i_rst_n  (sysrst_n),
            .i_raw    (Btn_Raw[g]),
            .o_stable (w_stable[g]),
            .o_pulse  (w_pulse[g])
        );
    end

    // Simultaneous Next and Pre is ambiguous, so neither is forwarded.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_next <= 1'b0;
            r_pre  <= 1'b0;
            r_auto <= 1'b0;
        end else begin
            r_next <= w_pulse[KEY_NEXT] & ~w_pulse[KEY_PRE];
            r_pre  <= w_pulse[KEY_PRE] & ~w_pulse[KEY_NEXT];
            r_auto <= w_pulse[KEY_AUTO];
        end
    end

    assign Bt_Next    = r_next;
    assign Bt_Pre     = r_pre;
    assign Bt_Auto    = r_auto;
    assign Btn_Stable = w_stable;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Scoreboard bench for key_pulse_gen: a reference model derived from the
// debounce/repeat rules feeds expected outputs for a repeat and a no-repeat DUT.
module tb_key_pulse_gen;

    localparam int DEB  = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int CW   = 8;
    localparam int HMAX = 20000;

    logic       sysclk   = 1'b0;
    logic       sysrst_n = 1'b0;
    logic [2:0] Btn_Raw  = 3'b000;

    logic       r1_next, r1_pre, r1_auto;
    logic [2:0] r1_stab;
    logic       r0_next, r0_pre, r0_auto;
    logic [2:0] r0_stab;

    always #5 sysclk = ~sysclk;

    key_pulse_gen #(.DEB_CYCLES(DEB), .RPT_DELAY(RD), .RPT_PERIOD(RP), .RPT_EN(1'b1), .CNT_W(CW)) dut (
        .sysclk(sysclk), .sysrst_n(sysrst_n), .Btn_Raw(Btn_Raw),
        .Bt_Next(r1_next), .Bt_Pre(r1_pre), .Bt_Auto(r1_auto), .Btn_Stable(r1_stab));

    key_pulse_gen #(.DEB_CYCLES(DEB), .RPT_DELAY(RD), .RPT_PERIOD(RP), .RPT_EN(1'b0), .CNT_W(CW)) dut_norpt (
        .sysclk(sysclk), .sysrst_n(sysrst_n), .Btn_Raw(Btn_Raw),
        .Bt_Next(r0_next), .Bt_Pre(r0_pre), .Bt_Auto(r0_auto), .Btn_Stable(r0_stab));

    typedef struct packed {
        logic [2:0] stab;
        logic n1, p1, a1, n0, p0, a0;
    } exp_t;

    typedef struct {
        string nm;
        int    act;
        int    exp;
    } chk_t;

    exp_t exp_q[$];
    chk_t chk_q[$];

    int total = 0;
    int bad   = 0;
    int cnt_n1 = 0, cnt_p1 = 0, cnt_a1 = 0, cnt_n0 = 0, cnt_a0 = 0;
    int last_n1 = -1, last_p1 = -1;

    // Reference history: raw level seen at each rising edge and debounced level after it.
    logic [2:0] raw_h  [HMAX];
    logic [2:0] stab_h [HMAX];
    int n = 0;
    int press_e   [3];
    int last_zero [3];

    function automatic bit raw_bit(int i, int c);
        if (i < 0) return 1'b0;
        return raw_h[i][c];
    endfunction

    function automatic bit stab_bit(int i, int c);
        if (i < 0) return 1'b0;
        return stab_h[i][c];
    endfunction

    always @(posedge sysclk) begin
        exp_t       e;
        logic [2:0] nst, pr, rp, pl;
        bit         prev, flip;
        e = '0;
        if (!sysrst_n) begin
            n = 0;
            for (int c = 0; c < 3; c++) begin
                press_e[c]   = -1000000;
                last_zero[c] = -1;
            end
            exp_q.push_back(e);
        end else if (n < HMAX) begin
            raw_h[n] = Btn_Raw;
            for (int c = 0; c < 3; c++) begin
                // Level flips once the synchronised input has disagreed for DEB edges running.
                prev = stab_bit(n - 1, c);
                flip = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (raw_bit(n - 2 - j, c) == prev) flip = 1'b0;
                nst[c] = flip ? ~prev : prev;
            end
            stab_h[n] = nst;
            for (int c = 0; c < 3; c++) begin
                if (!nst[c]) last_zero[c] = n;
                pr[c] = stab_bit(n - 1, c) && !stab_bit(n - 2, c);
                if (pr[c]) press_e[c] = n;
                rp[c] = (c != 2) && !pr[c] && (n - press_e[c] >= RD)
                        && (((n - press_e[c] - RD) % RP) == 0)
                        && (last_zero[c] < press_e[c] - 1);
                pl[c] = pr[c] | rp[c];
            end
            e.stab = nst;
            e.n1   = pl[0] & ~pl[1];
            e.p1   = pl[1] & ~pl[0];
            e.a1   = pr[2];
            e.n0   = pr[0] & ~pr[1];
            e.p0   = pr[1] & ~pr[0];
            e.a0   = pr[2];
            exp_q.push_back(e);
            n = n + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h want %0h", nm, n - 1, act, exp);
        end
    endtask

    always @(negedge sysclk) begin
        exp_t e;
        chk_t c;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rpt_dut {stab,next,pre,auto}", int'({r1_stab, r1_next, r1_pre, r1_auto}),
                int'({e.stab, e.n1, e.p1, e.a1}));
            chk("norpt_dut {stab,next,pre,auto}", int'({r0_stab, r0_next, r0_pre, r0_auto}),
                int'({e.stab, e.n0, e.p0, e.a0}));
        end
        if (r1_next) begin cnt_n1++; last_n1 = n - 1; end
        if (r1_pre)  begin cnt_p1++; last_p1 = n - 1; end
        if (r1_auto) cnt_a1++;
        if (r0_next) cnt_n0++;
        if (r0_auto) cnt_a0++;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            chk(c.nm, c.act, c.exp);
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(negedge sysclk);
            #1;
        end
    endtask

    task automatic req(input string nm, input int act, input int exp);
        chk_q.push_back('{nm, act, exp});
    endtask

    initial begin
        int sn1, sp1, sa1, sn0, sa0, nr, len;
        logic [2:0] v;
        bit bounce;

        // Reset with all buttons already held, then release and hold.
        Btn_Raw = 3'b111;
        tick(5);
        sysrst_n = 1'b1;
        tick(50);
        sysrst_n = 1'b0;
        #1;
        req("async_reset_outputs",
            int'({r1_next, r1_pre, r1_auto, r1_stab, r0_next, r0_pre, r0_auto, r0_stab}), 0);
        tick(3);
        Btn_Raw  = 3'b000;
        sysrst_n = 1'b1;
        tick(10);

        // Clean press and release on Next.
        nr = n;
        Btn_Raw[0] = 1'b1;
        tick(12);
        req("press_latency_edge", last_n1, nr + DEB + 2);
        Btn_Raw[0] = 1'b0;
        tick(15);

        // Bouncing Pre, then a steady hold.
        sp1 = cnt_p1;
        for (int i = 0; i < 10; i++) begin
            Btn_Raw[1] = ~Btn_Raw[1];
            tick(2);
        end
        Btn_Raw[1] = 1'b1;
        tick(12);
        Btn_Raw[1] = 1'b0;
        tick(12);
        req("bounce_pre_pulses", cnt_p1 - sp1, 1);

        // Hold-to-repeat on Next; Auto never repeats.
        sn1 = cnt_n1; sn0 = cnt_n0;
        Btn_Raw[0] = 1'b1;
        tick(60);
        Btn_Raw[0] = 1'b0;
        tick(15);
        req("repeat_next_pulses", cnt_n1 - sn1, 6);
        req("norpt_next_pulses", cnt_n0 - sn0, 1);
        sa1 = cnt_a1; sa0 = cnt_a0;
        Btn_Raw[2] = 1'b1;
        tick(60);
        Btn_Raw[2] = 1'b0;
        tick(15);
        req("hold_auto_pulses", cnt_a1 - sa1, 1);
        req("hold_auto_pulses_norpt", cnt_a0 - sa0, 1);

        // Next and Pre together: both suppressed, including their coinciding repeats.
        sn1 = cnt_n1; sp1 = cnt_p1;
        Btn_Raw[1:0] = 2'b11;
        tick(40);
        Btn_Raw[1:0] = 2'b00;
        tick(15);
        req("conflict_next_pulses", cnt_n1 - sn1, 0);
        req("conflict_pre_pulses", cnt_p1 - sp1, 0);

        // Pre three cycles after Next: both pass.
        sn1 = cnt_n1; sp1 = cnt_p1;
        Btn_Raw[0] = 1'b1;
        tick(3);
        Btn_Raw[1] = 1'b1;
        tick(12);
        Btn_Raw[1:0] = 2'b00;
        tick(15);
        req("stagger_next_pulses", cnt_n1 - sn1, 1);
        req("stagger_pre_pulses", cnt_p1 - sp1, 1);
        req("stagger_gap", last_p1 - last_n1, 3);

        // Random holds, releases and bursts of bounce, with one reset in the middle.
        for (int s = 0; s < 80; s++) begin
            v      = 3'($urandom_range(0, 7));
            len    = $urandom_range(1, 45);
            bounce = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < len; i++) begin
                Btn_Raw = bounce ? (v ^ 3'($urandom_range(0, 7))) : v;
                tick(1);
            end
            if (s == 40) begin
                sysrst_n = 1'b0;
                tick(2);
                sysrst_n = 1'b1;
            end
        end
        Btn_Raw = 3'b000;
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
